// File: rtl/ibex_l2_regfile_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ibex_l2_rf_pkg
// Shared types for the L2 register-file backing-store controller:
//   - l2_rf_state_e : read sequencer states
//   - wb_entry_t    : one posted-write buffer slot {addr, data}
//   - WbDepthDefault: default number of write-buffer slots
// Slot fields are sized for the widest supported configuration; narrower
// instances use the low bits only.
// ---------------------------------------------------------------------------
package ibex_l2_rf_pkg;

    localparam int unsigned WbDepthDefault = 2;
    localparam int unsigned MaxDataWidth   = 32;
    localparam int unsigned MaxAddrWidth   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        RESP = 2'd3
    } l2_rf_state_e;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] addr;
        logic [MaxDataWidth-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/ibex_l2_regfile_ctrl_if.sv
// ---------------------------------------------------------------------------
// ibex_l2_regfile_ctrl_if
// Bundles the front-end <-> L2 register-file request/response signals.
//   master : front-end side (drives requests, receives data/valid/ack/stall)
//   slave  : controller side
// Signals:
//   rd_a_req_i/rd_a_addr_i, rd_b_req_i/rd_b_addr_i : operand read requests
//   wr_req_i/wr_addr_i/wr_data_i                   : write-back request
//   rd_valid_o, rd_a_data_o, rd_b_data_o           : read response
//   wr_ack_o, stall_o                              : flow control
// ---------------------------------------------------------------------------
interface ibex_l2_regfile_ctrl_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 5
);
    import ibex_l2_rf_pkg::*;

    logic                 rd_a_req_i;
    logic [AddrWidth-1:0] rd_a_addr_i;
    logic                 rd_b_req_i;
    logic [AddrWidth-1:0] rd_b_addr_i;
    logic                 wr_req_i;
    logic [AddrWidth-1:0] wr_addr_i;
    logic [DataWidth-1:0] wr_data_i;
    logic                 rd_valid_o;
    logic [DataWidth-1:0] rd_a_data_o;
    logic [DataWidth-1:0] rd_b_data_o;
    logic                 wr_ack_o;
    logic                 stall_o;

    modport master (
        output rd_a_req_i, rd_a_addr_i, rd_b_req_i, rd_b_addr_i,
        output wr_req_i, wr_addr_i, wr_data_i,
        input  rd_valid_o, rd_a_data_o, rd_b_data_o, wr_ack_o, stall_o
    );

    modport slave (
        input  rd_a_req_i, rd_a_addr_i, rd_b_req_i, rd_b_addr_i,
        input  wr_req_i, wr_addr_i, wr_data_i,
        output rd_valid_o, rd_a_data_o, rd_b_data_o, wr_ack_o, stall_o
    );

endinterface

// File: rtl/ibex_l2_regfile_array.sv
// ---------------------------------------------------------------------------
// ibex_l2_regfile_array
// Single-ported 2**AddrWidth x DataWidth flop array. Entry 0 reads as zero
// and is never written.
//   clk_i, rst_ni : clock, async active-low clear of all entries
//   addr_i        : shared read/write address
//   we_i, wdata_i : synchronous write
//   rdata_o       : combinational read of addr_i
// ---------------------------------------------------------------------------
module ibex_l2_regfile_array
    import ibex_l2_rf_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic                 we_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic [DataWidth-1:0] rdata_o
);

    localparam int unsigned NumRegs = 2 ** AddrWidth;

    logic [DataWidth-1:0] mem_q [NumRegs];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (addr_i != '0)) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = (addr_i == '0) ? '0 : mem_q[addr_i];

endmodule

// File: rtl/ibex_l2_regfile_ctrl.sv
// ---------------------------------------------------------------------------
// ibex_l2_regfile_ctrl
// L2 register-file backing-store controller. Serialises operand-read misses
// onto a single-ported array and posts write-backs into a small FIFO that
// drains whenever the array port is idle. Reads see the youngest pending
// write (same-cycle write first, then the buffer) as of the accept cycle.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : read requests/response, write requests/ack, stall
// ---------------------------------------------------------------------------
module ibex_l2_regfile_ctrl
    import ibex_l2_rf_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned WbDepth   = WbDepthDefault
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    ibex_l2_regfile_ctrl_if.slave  bus
);

    localparam int unsigned PtrW = (WbDepth > 1) ? $clog2(WbDepth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    l2_rf_state_e         state_q, state_d;
    logic                 b_req_q, b_req_d;
    logic [AddrWidth-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic                 a_fwd_q, a_fwd_d, b_fwd_q, b_fwd_d;
    logic [DataWidth-1:0] a_fwd_data_q, a_fwd_data_d, b_fwd_data_q, b_fwd_data_d;
    logic [DataWidth-1:0] rd_a_data_q, rd_a_data_d, rd_b_data_q, rd_b_data_d;

    wb_entry_t            wb_q [WbDepth];
    logic [PtrW-1:0]      head_q, tail_q;
    logic [CntW-1:0]      count_q;

    logic                 any_rd_req, wb_full, wb_empty, drain, wr_ack, wr_push;
    logic [AddrWidth-1:0] arr_addr;
    logic [DataWidth-1:0] arr_rdata;

    assign any_rd_req = bus.rd_a_req_i | bus.rd_b_req_i;
    assign wb_full    = (count_q == CntW'(WbDepth));
    assign wb_empty   = (count_q == '0);
    // The array port is only free when no read is queued or pending.
    assign drain      = (state_q == IDLE) & ~any_rd_req & ~wb_empty;
    // A drain this cycle frees the head slot, so a full buffer can still accept.
    assign wr_ack     = bus.wr_req_i & (~wb_full | drain);
    // Writes to x0 are acknowledged but never stored.
    assign wr_push    = wr_ack & (bus.wr_addr_i != '0);

    // ---------------- forwarding lookup (evaluated at read accept) ----------
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [AddrWidth-1:0] req_addr;
        logic                 hit;
        logic [DataWidth-1:0] data;

        assign req_addr = (gi == 0) ? bus.rd_a_addr_i : bus.rd_b_addr_i;

        always_comb begin
            hit  = 1'b0;
            data = '0;
            // Walk oldest to youngest so the youngest match wins.
            for (int k = 0; k < WbDepth; k++) begin
                if ((CntW'(k) < count_q) &&
                    (wb_q[head_q + PtrW'(k)].addr[AddrWidth-1:0] == req_addr)) begin
                    hit  = 1'b1;
                    data = wb_q[head_q + PtrW'(k)].data[DataWidth-1:0];
                end
            end
            // A write landing in the same cycle is younger than anything buffered.
            if (wr_push && (bus.wr_addr_i == req_addr)) begin
                hit  = 1'b1;
                data = bus.wr_data_i;
            end
        end
    end

    // ---------------- read sequencer ----------------------------------------
    always_comb begin
        state_d      = state_q;
        b_req_d      = b_req_q;
        a_addr_d     = a_addr_q;
        b_addr_d     = b_addr_q;
        a_fwd_d      = a_fwd_q;
        b_fwd_d      = b_fwd_q;
        a_fwd_data_d = a_fwd_data_q;
        b_fwd_data_d = b_fwd_data_q;
        rd_a_data_d  = rd_a_data_q;
        rd_b_data_d  = rd_b_data_q;

        unique case (state_q)
            IDLE: begin
                if (any_rd_req) begin
                    b_req_d      = bus.rd_b_req_i;
                    a_addr_d     = bus.rd_a_addr_i;
                    b_addr_d     = bus.rd_b_addr_i;
                    a_fwd_d      = g_fwd[0].hit;
                    a_fwd_data_d = g_fwd[0].data;
                    b_fwd_d      = g_fwd[1].hit;
                    b_fwd_data_d = g_fwd[1].data;
                    state_d      = bus.rd_a_req_i ? RD_A : RD_B;
                end
            end
            RD_A: begin
                rd_a_data_d = a_fwd_q ? a_fwd_data_q : arr_rdata;
                state_d     = b_req_q ? RD_B : RESP;
            end
            RD_B: begin
                rd_b_data_d = b_fwd_q ? b_fwd_data_q : arr_rdata;
                state_d     = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            b_req_q      <= 1'b0;
            a_addr_q     <= '0;
            b_addr_q     <= '0;
            a_fwd_q      <= 1'b0;
            b_fwd_q      <= 1'b0;
            a_fwd_data_q <= '0;
            b_fwd_data_q <= '0;
            rd_a_data_q  <= '0;
            rd_b_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            b_req_q      <= b_req_d;
            a_addr_q     <= a_addr_d;
            b_addr_q     <= b_addr_d;
            a_fwd_q      <= a_fwd_d;
            b_fwd_q      <= b_fwd_d;
            a_fwd_data_q <= a_fwd_data_d;
            b_fwd_data_q <= b_fwd_data_d;
            rd_a_data_q  <= rd_a_data_d;
            rd_b_data_q  <= rd_b_data_d;
        end
    end

    // ---------------- posted write buffer -----------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_push) begin
                tail_q <= tail_q + PtrW'(1);
            end
            if (drain) begin
                head_q <= head_q + PtrW'(1);
            end
            unique case ({wr_push, drain})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Slot payload is only meaningful below count_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (wr_push) begin
            wb_q[tail_q] <= '{addr: MaxAddrWidth'(bus.wr_addr_i),
                              data: MaxDataWidth'(bus.wr_data_i)};
        end
    end

    // ---------------- array port --------------------------------------------
    always_comb begin
        unique case (state_q)
            RD_A:    arr_addr = a_addr_q;
            RD_B:    arr_addr = b_addr_q;
            default: arr_addr = wb_q[head_q].addr[AddrWidth-1:0];
        endcase
    end

    ibex_l2_regfile_array #(
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth)
    ) u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .addr_i  (arr_addr),
        .we_i    (drain),
        .wdata_i (wb_q[head_q].data[DataWidth-1:0]),
        .rdata_o (arr_rdata)
    );

    // ---------------- outputs -----------------------------------------------
    assign bus.rd_valid_o  = (state_q == RESP);
    assign bus.rd_a_data_o = rd_a_data_q;
    assign bus.rd_b_data_o = rd_b_data_q;
    assign bus.wr_ack_o    = wr_ack;
    // Stall is released in RESP so the held instruction advances in the same
    // cycle its operands become valid.
    assign bus.stall_o     = (state_q == RD_A) | (state_q == RD_B) |
                             ((state_q == IDLE) & any_rd_req) |
                             (bus.wr_req_i & ~wr_ack);

endmodule

// File: tb/tb_ibex_l2_regfile_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ibex_l2_regfile_ctrl
// Directed bench for the L2 register-file controller. Each call to cyc()
// drives one clock cycle of inputs and samples the outputs at the falling
// edge; expected values are hand-computed per cycle.
// ---------------------------------------------------------------------------
module tb_ibex_l2_regfile_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ibex_l2_regfile_ctrl_if #(.DataWidth(DW), .AddrWidth(AW)) bus_if ();

    ibex_l2_regfile_ctrl #(
        .DataWidth (DW),
        .AddrWidth (AW),
        .WbDepth   (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic          s_valid, s_stall, s_ack;
    logic [DW-1:0] s_a, s_b;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, obs);
        end
    endtask

    // One cycle: drive at posedge+1, sample at negedge, return at next posedge+1.
    task automatic cyc(input logic ra, input logic [AW-1:0] aa,
                       input logic rb, input logic [AW-1:0] ba,
                       input logic w,  input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bus_if.rd_a_req_i  = ra;
        bus_if.rd_a_addr_i = aa;
        bus_if.rd_b_req_i  = rb;
        bus_if.rd_b_addr_i = ba;
        bus_if.wr_req_i    = w;
        bus_if.wr_addr_i   = wa;
        bus_if.wr_data_i   = wd;
        @(negedge clk);
        s_valid = bus_if.rd_valid_o;
        s_stall = bus_if.stall_o;
        s_ack   = bus_if.wr_ack_o;
        s_a     = bus_if.rd_a_data_o;
        s_b     = bus_if.rd_b_data_o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(bus_if.rd_valid_o), 32'd0);
        check_eq({tag, "_a"},     bus_if.rd_a_data_o,     32'd0);
        check_eq({tag, "_b"},     bus_if.rd_b_data_o,     32'd0);
        check_eq({tag, "_ack"},   32'(bus_if.wr_ack_o),   32'd0);
        check_eq({tag, "_stall"}, 32'(bus_if.stall_o),    32'd0);
    endtask

    initial begin
        bus_if.rd_a_req_i  = 1'b0;
        bus_if.rd_a_addr_i = '0;
        bus_if.rd_b_req_i  = 1'b0;
        bus_if.rd_b_addr_i = '0;
        bus_if.wr_req_i    = 1'b0;
        bus_if.wr_addr_i   = '0;
        bus_if.wr_data_i   = '0;

        // ---- reset state ----
        #12;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- 1: write x5, single-operand read latency and stall ----
        cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        check_eq("t1_wr_ack", 32'(s_ack), 32'd1);
        check_eq("t1_wr_stall", 32'(s_stall), 32'd0);
        idle(2);
        cyc(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        check_eq("t1_stall_t0", 32'(s_stall), 32'd1);
        check_eq("t1_valid_t0", 32'(s_valid), 32'd0);
        cyc(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        check_eq("t1_stall_t1", 32'(s_stall), 32'd1);
        check_eq("t1_valid_t1", 32'(s_valid), 32'd0);
        cyc(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        check_eq("t1_valid_t2", 32'(s_valid), 32'd1);
        check_eq("t1_stall_t2", 32'(s_stall), 32'd0);
        check_eq("t1_rd_a", s_a, 32'hDEAD_BEEF);
        idle(1);

        // ---- 2: two-operand read ----
        cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h11);
        check_eq("t2_ack_x7", 32'(s_ack), 32'd1);
        cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 32'h22);
        check_eq("t2_ack_x8", 32'(s_ack), 32'd1);
        cyc(1'b1, 5'd7, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd7, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd7, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0);
        check_eq("t2_valid_t2", 32'(s_valid), 32'd0);
        cyc(1'b1, 5'd7, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0);
        check_eq("t2_valid_t3", 32'(s_valid), 32'd1);
        check_eq("t2_rd_a", s_a, 32'h11);
        check_eq("t2_rd_b", s_b, 32'h22);
        idle(2);

        // ---- 3: youngest buffered write is forwarded ----
        cyc(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd9, 32'h1);
        check_eq("t3_ack_first", 32'(s_ack), 32'd1);
        cyc(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd9, 32'h2);
        check_eq("t3_ack_second", 32'(s_ack), 32'd1);
        check_eq("t3_dummy_valid", 32'(s_valid), 32'd1);
        check_eq("t3_dummy_rd_a", s_a, 32'd0);
        cyc(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        check_eq("t3_fwd_valid", 32'(s_valid), 32'd1);
        check_eq("t3_fwd_rd_a", s_a, 32'h2);
        idle(3);
        cyc(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        check_eq("t3_array_rd_a", s_a, 32'h2);
        idle(1);

        // ---- 4: same-cycle write/read forwarding ----
        cyc(1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd10, 32'h55);
        check_eq("t4_ack", 32'(s_ack), 32'd1);
        check_eq("t4_stall", 32'(s_stall), 32'd1);
        cyc(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        check_eq("t4_valid", 32'(s_valid), 32'd1);
        check_eq("t4_rd_a", s_a, 32'h55);
        idle(2);

        // ---- 5: buffer full during a read, third write waits for drain ----
        cyc(1'b1, 5'd7, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd20, 32'hA1);
        check_eq("t5_ack_1", 32'(s_ack), 32'd1);
        cyc(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd21, 32'hA2);
        check_eq("t5_ack_2", 32'(s_ack), 32'd1);
        cyc(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd22, 32'hA3);
        check_eq("t5_full_ack", 32'(s_ack), 32'd0);
        check_eq("t5_full_stall", 32'(s_stall), 32'd1);
        check_eq("t5_valid", 32'(s_valid), 32'd1);
        check_eq("t5_rd_a", s_a, 32'h11);
        check_eq("t5_rd_b", s_b, 32'h22);
        cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd22, 32'hA3);
        check_eq("t5_drain_ack", 32'(s_ack), 32'd1);
        check_eq("t5_drain_stall", 32'(s_stall), 32'd0);
        idle(3);
        cyc(1'b1, 5'd20, 1'b1, 5'd21, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd20, 1'b1, 5'd21, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd20, 1'b1, 5'd21, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd20, 1'b1, 5'd21, 1'b0, 5'd0, 32'd0);
        check_eq("t5_arr_x20", s_a, 32'hA1);
        check_eq("t5_arr_x21", s_b, 32'hA2);
        cyc(1'b1, 5'd22, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd22, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd22, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        check_eq("t5_arr_x22", s_a, 32'hA3);
        idle(1);

        // ---- 6: x0 is hardwired to zero ----
        cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFF);
        check_eq("t6_ack_x0", 32'(s_ack), 32'd1);
        idle(1);
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        check_eq("t6_valid", 32'(s_valid), 32'd1);
        check_eq("t6_rd_x0", s_a, 32'd0);
        idle(1);

        // ---- 7: async reset in RD_B discards read and buffered write ----
        cyc(1'b1, 5'd7, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd13, 32'h77);
        check_eq("t7_ack_x13", 32'(s_ack), 32'd1);
        // Now in RD_B; operand A was captured on the last edge.
        check_eq("t7_pre_rst_a", bus_if.rd_a_data_o, 32'h11);
        bus_if.rd_a_req_i = 1'b0;
        bus_if.rd_b_req_i = 1'b0;
        bus_if.wr_req_i   = 1'b0;
        rst_n = 1'b0;
        #2;
        check_outputs_zero("t7_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1);
        cyc(1'b1, 5'd13, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd13, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd13, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        check_eq("t7_valid_x13", 32'(s_valid), 32'd1);
        check_eq("t7_rd_x13", s_a, 32'd0);
        cyc(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        check_eq("t7_rd_x5_cleared", s_a, 32'd0);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
